// File: rtl/pool_apb_pkg.sv
// Shared register map, step encoding and FSM states for the pool block's APB interface.
// The pool block's APB slave decodes the same offsets.
package pool_apb_pkg;

  localparam logic [31:0] REG_CTRL    = 32'h00;
  localparam logic [31:0] REG_STATUS  = 32'h04;
  localparam logic [31:0] REG_IN_SIZE = 32'h08;
  localparam logic [31:0] REG_CH_SIZE = 32'h0C;
  localparam logic [31:0] REG_CLK_CNT = 32'h10;

  localparam int CTRL_START_BIT  = 0;
  localparam int STATUS_DONE_BIT = 0;

  // Ordered: every step at or after STEP_START runs with start set in the slave.
  typedef enum logic [2:0] {
    STEP_IN_SIZE = 3'd0,
    STEP_CH_SIZE = 3'd1,
    STEP_START   = 3'd2,
    STEP_POLL    = 3'd3,
    STEP_CLK_CNT = 3'd4,
    STEP_CLEAR   = 3'd5
  } step_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } apb_cmd_t;

  function automatic apb_cmd_t step_cmd(input step_t step, input logic [5:0] in_size,
                                        input logic [8:0] ch_size);
    apb_cmd_t c;
    c = '0;
    case (step)
      STEP_IN_SIZE: begin c.addr = REG_IN_SIZE; c.write = 1'b1; c.wdata = {26'd0, in_size}; end
      STEP_CH_SIZE: begin c.addr = REG_CH_SIZE; c.write = 1'b1; c.wdata = {23'd0, ch_size}; end
      STEP_START:   begin c.addr = REG_CTRL;    c.write = 1'b1; c.wdata = 32'd1 << CTRL_START_BIT; end
      STEP_POLL:    begin c.addr = REG_STATUS;  c.write = 1'b0; end
      STEP_CLK_CNT: begin c.addr = REG_CLK_CNT; c.write = 1'b0; end
      default:      begin c.addr = REG_CTRL;    c.write = 1'b1; c.wdata = 32'd0; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/apb_req_port.sv
// Single-transfer APB requester: req drives the SETUP cycle, ACCESS follows and holds until PREADY.
// done/err/rdata are valid combinationally in the completing ACCESS cycle; caller may req again then.
module apb_req_port
  import pool_apb_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  logic        access_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      access_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
    end else if (req) begin
      access_q <= 1'b1;
      addr_q   <= addr;
      write_q  <= write;
      wdata_q  <= wdata;
    end else if (access_q && PREADY) begin
      access_q <= 1'b0;
    end
  end

  // Address/control come straight from the caller in SETUP, then from the latched copy.
  assign PSEL    = req | access_q;
  assign PENABLE = access_q;
  assign PADDR   = req ? addr  : addr_q;
  assign PWRITE  = req ? write : write_q;
  assign PWDATA  = req ? wdata : wdata_q;

  assign done  = access_q & PREADY;
  assign err   = done & PSLVERR;
  assign rdata = PRDATA;

endmodule

// File: rtl/pool_apb_sequencer.sv
// Runs one pooling job over APB: size writes, start, STATUS polling, CLK_CNT read, start clear, report.
// job_done 13 cycles after accept with a zero-wait slave; APB wait states simply stretch each ACCESS.
module pool_apb_sequencer
  import pool_apb_pkg::*;
#(
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 65535
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [5:0]  job_input_size,
  input  logic [8:0]  job_channel_size,
  output logic        job_done,
  output logic        job_err,
  output logic [31:0] job_cycles,
  output logic        busy,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [16:0] MAX_POLLS_W = 17'(MAX_POLLS);

  state_t      state_q, state_n;
  step_t       step_q, step_n;
  logic [5:0]  in_size_q, in_size_n;
  logic [8:0]  ch_size_q, ch_size_n;
  logic [15:0] poll_q, poll_n;
  logic [15:0] gap_q, gap_n;
  logic        err_q, err_n;
  logic [31:0] cnt_q, cnt_n;
  logic [31:0] cycles_q, cycles_n;

  apb_cmd_t    cmd;
  logic        xfer_done;
  logic        xfer_err;
  logic [31:0] xfer_rdata;

  assign cmd = step_cmd(step_q, in_size_q, ch_size_q);

  apb_req_port u_port (
    .CLK     (CLK),
    .RESET   (RESET),
    .req     (state_q == ST_SETUP),
    .addr    (cmd.addr),
    .write   (cmd.write),
    .wdata   (cmd.wdata),
    .done    (xfer_done),
    .rdata   (xfer_rdata),
    .err     (xfer_err),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      step_q    <= STEP_IN_SIZE;
      in_size_q <= '0;
      ch_size_q <= '0;
      poll_q    <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_n;
      step_q    <= step_n;
      in_size_q <= in_size_n;
      ch_size_q <= ch_size_n;
      poll_q    <= poll_n;
      gap_q     <= gap_n;
      err_q     <= err_n;
      cnt_q     <= cnt_n;
      cycles_q  <= cycles_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    step_n    = step_q;
    in_size_n = in_size_q;
    ch_size_n = ch_size_q;
    poll_n    = poll_q;
    gap_n     = gap_q;
    err_n     = err_q;
    cnt_n     = cnt_q;
    cycles_n  = cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          state_n   = ST_SETUP;
          step_n    = STEP_IN_SIZE;
          in_size_n = job_input_size;
          ch_size_n = job_channel_size;
          poll_n    = '0;
          gap_n     = '0;
          err_n     = 1'b0;
        end
      end
      ST_SETUP: state_n = ST_ACCESS;
      ST_ACCESS: begin
        if (xfer_done) begin
          state_n = ST_SETUP;
          if (step_q == STEP_CLEAR) begin
            // Final clear: an error here is reported but never retried.
            state_n = ST_REPORT;
            if (xfer_err) err_n = 1'b1;
          end else if (xfer_err) begin
            err_n = 1'b1;
            if (step_q >= STEP_START) step_n = STEP_CLEAR;
            else                      state_n = ST_REPORT;
          end else begin
            case (step_q)
              STEP_IN_SIZE: step_n = STEP_CH_SIZE;
              STEP_CH_SIZE: step_n = STEP_START;
              STEP_START:   step_n = STEP_POLL;
              STEP_POLL: begin
                poll_n = poll_q + 16'd1;
                if (xfer_rdata[STATUS_DONE_BIT]) begin
                  step_n = STEP_CLK_CNT;
                end else if ({1'b0, poll_q} + 17'd1 >= MAX_POLLS_W) begin
                  err_n  = 1'b1;
                  step_n = STEP_CLEAR;
                end else if (POLL_GAP != 0) begin
                  state_n = ST_GAP;
                  gap_n   = '0;
                end
              end
              STEP_CLK_CNT: begin
                cnt_n  = xfer_rdata;
                step_n = STEP_CLEAR;
              end
              default: state_n = ST_REPORT;
            endcase
          end
        end
      end
      ST_GAP: begin
        gap_n = gap_q + 16'd1;
        if (gap_q == GAP_LAST) state_n = ST_SETUP;
      end
      ST_REPORT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    // The cycle count becomes visible together with job_done, and only for a clean job.
    if (state_n == ST_REPORT && state_q != ST_REPORT && !err_n) cycles_n = cnt_q;
  end

  assign job_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign job_done   = (state_q == ST_REPORT);
  assign job_err    = (state_q == ST_REPORT) && err_q;
  assign job_cycles = cycles_q;

endmodule

// File: tb/tb_pool_apb_sequencer.sv
// Bench for pool_apb_sequencer: per-cycle timeline model of each job against a randomized APB slave,
// plus directed jobs with hand-computed latencies and transfer sequences.
module tb_pool_apb_sequencer;

  localparam int GAP  = 4;
  localparam int MAXP = 6;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [5:0]  job_input_size = '0;
  logic [8:0]  job_channel_size = '0;
  logic        job_done;
  logic        job_err;
  logic [31:0] job_cycles;
  logic        busy;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  pool_apb_sequencer #(.POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
    .CLK(CLK), .RESET(RESET),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_input_size(job_input_size), .job_channel_size(job_channel_size),
    .job_done(job_done), .job_err(job_err), .job_cycles(job_cycles), .busy(busy),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit          psel, pen, wr, busy, done, err;
    logic [31:0] addr, wdata, cyc_val;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] data;
  } xfer_t;

  exp_t        tl[$];
  xfer_t       seen[$];
  bit          model_en = 1'b0;
  logic [31:0] shown_cycles = '0;

  // Slave scenario for the current job
  int          waits[16];
  int          err_idx = -1;
  int          done_poll = 1;
  logic [31:0] cnt_val = '0;
  int          sk = 0, spoll = 0, acc_cnt = 0;
  bit          completing = 1'b0;

  int          done_cyc = 0, done_count = 0;
  bit          done_err = 1'b0;
  logic [31:0] done_cycles = '0;

  localparam logic [31:0] T1_ADDR [6] = '{32'h08, 32'h0C, 32'h00, 32'h04, 32'h10, 32'h00};
  localparam bit          T1_WR   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] T1_DATA [6] = '{32'd16, 32'd64, 32'd1, 32'd0, 32'd0, 32'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Per-cycle comparison against the timeline model
  initial forever begin
    exp_t e;
    bit   bad;
    @(negedge CLK);
    if (model_en) begin
      if (tl.size() > 0) e = tl.pop_front();
      else begin
        e = '{psel: 0, pen: 0, wr: 0, busy: 0, done: 0, err: 0, addr: '0, wdata: '0, cyc_val: shown_cycles};
      end
      bad = (PSEL !== e.psel) || (PENABLE !== e.pen) || (busy !== e.busy) ||
            (job_ready !== !e.busy) || (job_done !== e.done) || (job_cycles !== e.cyc_val) ||
            (e.done && job_err !== e.err) ||
            (e.psel && (PADDR !== e.addr || PWRITE !== e.wr || (e.wr && PWDATA !== e.wdata)));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL cycle_compare cyc=%0d got/expected psel=%b/%b pen=%b/%b addr=%h/%h wr=%b/%b wd=%h/%h busy=%b/%b ready=%b done=%b/%b err=%b/%b cycles=%h/%h",
                 cyc, PSEL, e.psel, PENABLE, e.pen, PADDR, e.addr, PWRITE, e.wr, PWDATA, e.wdata,
                 busy, e.busy, job_ready, job_done, e.done, job_err, e.err, job_cycles, e.cyc_val);
      end
    end
    if (job_done === 1'b1) begin
      done_cyc    = cyc;
      done_err    = job_err;
      done_cycles = job_cycles;
      done_count++;
    end
  end

  // APB slave: waits[k] wait states on transfer k, PSLVERR on transfer err_idx
  initial forever begin
    logic [31:0] r;
    @(posedge CLK);
    #1;
    if (RESET) begin
      sk = 0; spoll = 0; acc_cnt = 0; completing = 1'b0;
      PREADY = 1'b0; PSLVERR = 1'b0;
    end else begin
      if (completing) begin
        sk++; acc_cnt = 0; completing = 1'b0;
      end
      r = $urandom;
      if (PSEL && PENABLE) begin
        if (acc_cnt >= waits[sk % 16]) begin
          PREADY  = 1'b1;
          PSLVERR = (sk == err_idx);
          if (!PWRITE && PADDR == 32'h04) begin
            spoll++;
            r[0] = (spoll == done_poll);
            PRDATA = r;
          end else if (!PWRITE && PADDR == 32'h10) PRDATA = cnt_val;
          else PRDATA = r;
          completing = 1'b1;
          seen.push_back('{addr: PADDR, wr: PWRITE, data: PWDATA});
        end else begin
          PREADY = 1'b0; PSLVERR = r[1]; PRDATA = r; acc_cnt++;
        end
      end else begin
        PREADY = r[0]; PSLVERR = r[1]; PRDATA = r;
      end
    end
  end

  task automatic push_xfer(input logic [31:0] a, input bit w, input logic [31:0] d, input int k);
    exp_t e;
    e = '{psel: 1, pen: 0, wr: w, busy: 1, done: 0, err: 0, addr: a, wdata: d, cyc_val: shown_cycles};
    tl.push_back(e);
    e.pen = 1;
    for (int i = 0; i <= waits[k % 16]; i++) tl.push_back(e);
  endtask

  task automatic push_idle(input bit b);
    exp_t e;
    e = '{psel: 0, pen: 0, wr: 0, busy: b, done: 0, err: 0, addr: '0, wdata: '0, cyc_val: shown_cycles};
    tl.push_back(e);
  endtask

  // Expands one job into its expected cycle-by-cycle outputs from the step rules
  task automatic build_job(input logic [5:0] sz, input logic [8:0] ch);
    int k = 0;
    int p = 0;
    bit err = 0;
    bit started = 0;
    exp_t e;
    push_idle(1'b0);
    push_xfer(32'h08, 1, {26'd0, sz}, k); err = (k == err_idx); k++;
    if (!err) begin push_xfer(32'h0C, 1, {23'd0, ch}, k); err = (k == err_idx); k++; end
    if (!err) begin started = 1; push_xfer(32'h00, 1, 32'd1, k); err = (k == err_idx); k++; end
    if (!err) begin
      while (1) begin
        p++;
        push_xfer(32'h04, 0, 32'd0, k);
        if (k == err_idx) begin err = 1; k++; break; end
        k++;
        if (p == done_poll) break;
        if (p == MAXP) begin err = 1; break; end
        repeat (GAP) push_idle(1'b1);
      end
      if (!err) begin push_xfer(32'h10, 0, 32'd0, k); err = (k == err_idx); k++; end
    end
    if (started) begin push_xfer(32'h00, 1, 32'd0, k); if (k == err_idx) err = 1; k++; end
    e = '{psel: 0, pen: 0, wr: 0, busy: 1, done: 1, err: err, addr: '0, wdata: '0,
          cyc_val: err ? shown_cycles : cnt_val};
    tl.push_back(e);
    shown_cycles = e.cyc_val;
  endtask

  task automatic run_job(input logic [5:0] sz, input logic [8:0] ch, input int dp, input int ei,
                         input logic [31:0] cv, input int wmin, input int wmax, output int acc);
    int guard = 0;
    while (tl.size() > 1 && guard < 5000) begin @(posedge CLK); #2; guard++; end
    if (guard >= 5000) check("job_slot_timeout", 32'd1, 32'd0);
    acc = cyc + tl.size();
    done_poll = dp; err_idx = ei; cnt_val = cv;
    for (int i = 0; i < 16; i++) waits[i] = $urandom_range(wmax, wmin);
    sk = 0; spoll = 0;
    seen.delete();
    job_valid = 1'b1; job_input_size = sz; job_channel_size = ch;
    build_job(sz, ch);
    guard = 0;
    do begin @(posedge CLK); #2; guard++; end while (cyc <= acc && guard < 10);
    job_valid = 1'b0;
    job_input_size = 6'($urandom);
    job_channel_size = 9'($urandom);
  endtask

  task automatic wait_end();
    int guard = 0;
    while (tl.size() > 0 && guard < 5000) begin @(posedge CLK); #2; guard++; end
    if (guard >= 5000) check("job_end_timeout", 32'd1, 32'd0);
  endtask

  function automatic int count_addr(input logic [31:0] a, input bit w);
    int n = 0;
    foreach (seen[i]) if (seen[i].addr == a && seen[i].wr == w) n++;
    return n;
  endfunction

  initial begin
    int acc;
    int nd;
    #1;
    check("reset_psel", {31'd0, PSEL}, 32'd0);
    check("reset_penable", {31'd0, PENABLE}, 32'd0);
    check("reset_job_ready", {31'd0, job_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_job_done", {31'd0, job_done}, 32'd0);
    check("reset_job_cycles", job_cycles, 32'd0);
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;
    model_en = 1'b1;
    repeat (2) begin @(posedge CLK); #2; end

    // Zero-wait slave, done on first poll
    run_job(6'd16, 9'd64, 1, -1, 32'h1234, 0, 0, acc);
    wait_end();
    check("t1_latency", done_cyc - acc, 32'd13);
    check("t1_err", {31'd0, done_err}, 32'd0);
    check("t1_cycles", done_cycles, 32'h1234);
    check("t1_xfer_count", seen.size(), 32'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      check($sformatf("t1_addr%0d", i), seen[i].addr, T1_ADDR[i]);
      check($sformatf("t1_wr%0d", i), {31'd0, seen[i].wr}, {31'd0, T1_WR[i]});
      if (T1_WR[i]) check($sformatf("t1_wdata%0d", i), seen[i].data, T1_DATA[i]);
    end

    // Three wait states on every transfer
    run_job(6'd16, 9'd64, 1, -1, 32'h4321, 3, 3, acc);
    wait_end();
    check("t2_latency", done_cyc - acc, 32'd31);
    check("t2_cycles", done_cycles, 32'h4321);

    // Done on fifth poll, four idle cycles between polls
    run_job(6'd5, 9'd300, 5, -1, 32'hBEEF, 0, 0, acc);
    wait_end();
    check("t3_status_reads", count_addr(32'h04, 0), 32'd5);
    check("t3_latency", done_cyc - acc, 32'd37);
    check("t3_cycles", done_cycles, 32'hBEEF);

    // Slave error on the CH_SIZE write
    run_job(6'd9, 9'd17, 1, 1, 32'h5555, 0, 0, acc);
    wait_end();
    check("t4_xfer_count", seen.size(), 32'd2);
    check("t4_ctrl_writes", count_addr(32'h00, 1), 32'd0);
    check("t4_latency", done_cyc - acc, 32'd5);
    check("t4_err", {31'd0, done_err}, 32'd1);
    check("t4_cycles_held", done_cycles, 32'hBEEF);

    // Poll timeout after MAXP reads
    run_job(6'd33, 9'd1, 0, -1, 32'h6666, 0, 0, acc);
    wait_end();
    check("t5_status_reads", count_addr(32'h04, 0), MAXP);
    check("t5_last_addr", (seen.size() > 0) ? seen[seen.size()-1].addr : 32'hFFFF_FFFF, 32'h00);
    check("t5_last_wdata", (seen.size() > 0) ? seen[seen.size()-1].data : 32'hFFFF_FFFF, 32'h0);
    check("t5_latency", done_cyc - acc, 32'd41);
    check("t5_err", {31'd0, done_err}, 32'd1);

    // Random jobs, often back-to-back with job_valid raised in the REPORT cycle
    for (int j = 0; j < 40; j++) begin
      run_job(6'($urandom), 9'($urandom), $urandom_range(0, 7),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1,
              $urandom, 0, $urandom_range(0, 3), acc);
      if ($urandom_range(0, 2) == 0) begin
        wait_end();
        repeat ($urandom_range(0, 3)) begin @(posedge CLK); #2; end
      end
    end
    wait_end();

    // Reset during ACCESS of the start write
    run_job(6'd16, 9'd64, 1, -1, 32'h7777, 0, 0, acc);
    while (cyc < acc + 6) begin @(posedge CLK); #2; end
    check("rst_pre_penable", {31'd0, PENABLE}, 32'd1);
    check("rst_pre_paddr", PADDR, 32'h00);
    model_en = 1'b0;
    tl.delete();
    RESET = 1'b1;
    #1;
    check("rst_psel", {31'd0, PSEL}, 32'd0);
    check("rst_penable", {31'd0, PENABLE}, 32'd0);
    nd = done_count;
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
    shown_cycles = '0;
    check("rst_job_ready", {31'd0, job_ready}, 32'd1);
    model_en = 1'b1;
    repeat (20) begin @(posedge CLK); #2; end
    check("rst_no_job_done", done_count, nd);

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
